// File: rtl/snes_pad_poller.sv
// snes_pad_poller: drives the shared SNES latch/clock lines to NUM_PADS pads,
// shifts in each pad's serial word and publishes a whole-frame button vector
// with per-button press/release strobes, on demand or from an auto timer.
//
// Request semantics: start is a one-cycle request honoured only when the
// poller is idle (busy=0); a start seen while busy is dropped, not queued.
// The auto timer raises a request that is held until the next launch.
// valid, pressed and released are one-cycle strobes, all in the same cycle.
module snes_pad_poller #(
  parameter int NUM_PADS   = 2,
  parameter int NUM_BITS   = 16,
  parameter int HALF_TICKS = 300,
  parameter int POLL_TICKS = 833333
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         auto_en,
  input  logic                         start,
  output logic                         data_latch,
  output logic                         data_pulse,
  input  logic [NUM_PADS-1:0]          data_in,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         valid,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);

  localparam int PH_W  = $clog2(2 * HALF_TICKS);
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int TMR_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam int WORD_W = NUM_PADS * NUM_BITS;

  localparam logic [PH_W-1:0]  PH_HALF_LAST  = PH_W'(HALF_TICKS - 1);
  localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(2 * HALF_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(NUM_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(POLL_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_LO = 3'd2,
    S_CLK_HI = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q;
  logic [PH_W-1:0]    phase_q;
  logic [BIT_W-1:0]   bit_q;
  logic               latch_q;
  logic               pulse_q;
  logic               busy_q;
  logic               valid_q;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  buttons_q;
  logic [WORD_W-1:0]  pressed_q;
  logic [WORD_W-1:0]  released_q;

  logic [NUM_PADS-1:0] sync1_q;
  logic [NUM_PADS-1:0] sync2_q;

  logic [TMR_W-1:0]   timer_q;
  logic [TMR_W-1:0]   timer_d;
  logic               pending_q;
  logic               pending_d;
  logic               expire;
  logic               launch;

  // The timer expiry counts as a request in the cycle it happens, so an idle
  // poller launches exactly POLL_TICKS cycles after the previous launch.
  assign expire = auto_en && (timer_q == TMR_LAST);
  assign launch = (state_q == S_IDLE) && (start || pending_q || expire);

  // Two-flop synchroniser per pad data line; the wire idles high (released).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  // Auto-poll timer and held request: restart on launch, cleared when disabled.
  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!auto_en) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else if (launch) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      if (timer_q != TMR_LAST) begin
        timer_d = timer_q + 1'b1;
      end
      if (expire) begin
        pending_d = 1'b1;
      end
    end
  end

  // Timer and pending-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // Poll sequencer: latch pulse, NUM_BITS clock pulses, then one publish cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      valid_q    <= 1'b0;
      pressed_q  <= '0;
      released_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q <= S_LATCH;
            phase_q <= '0;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LATCH: begin
          if (phase_q == PH_LATCH_LAST) begin
            state_q <= S_CLK_LO;
            phase_q <= '0;
            bit_q   <= '0;
            latch_q <= 1'b0;
            pulse_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (phase_q == PH_HALF_LAST) begin
            // Sample just before the rising edge; the wire is active-low.
            for (int p = 0; p < NUM_PADS; p++) begin
              word_q[p*NUM_BITS + int'(bit_q)] <= ~sync2_q[p];
            end
            state_q <= S_CLK_HI;
            phase_q <= '0;
            pulse_q <= 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (phase_q == PH_HALF_LAST) begin
            phase_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q    <= S_DONE;
              buttons_q  <= word_q;
              pressed_q  <= word_q & ~buttons_q;
              released_q <= ~word_q & buttons_q;
              valid_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              state_q <= S_CLK_LO;
              pulse_q <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          latch_q <= 1'b0;
          pulse_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_latch = latch_q;
  assign data_pulse = pulse_q;
  assign buttons    = buttons_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_snes_pad_poller.sv
// tb_snes_pad_poller: directed sequence of polls against serial pad models,
// with a frame-level reference for expected pin timing and button reports.
module tb_snes_pad_poller;

  localparam int NP = 2;
  localparam int N  = 16;
  localparam int H  = 4;
  localparam int PT = 200;
  localparam int NW = NP * N;
  localparam int LAT_CYC = 2 * H;
  localparam int DONE_J  = 2 * H + 2 * H * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          auto_en = 1'b0;
  logic          start = 1'b0;
  logic          data_latch;
  logic          data_pulse;
  logic [NP-1:0] data_in = '1;
  logic [NW-1:0] buttons;
  logic [NW-1:0] pressed;
  logic [NW-1:0] released;
  logic          valid;
  logic          busy;
  logic [2:0]    state_dbg;

  snes_pad_poller #(
    .NUM_PADS(NP), .NUM_BITS(N), .HALF_TICKS(H), .POLL_TICKS(PT)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .start(start),
    .data_latch(data_latch), .data_pulse(data_pulse), .data_in(data_in),
    .buttons(buttons), .pressed(pressed), .released(released),
    .valid(valid), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_launch = 0;
  int exp_polls = 0;
  logic [NW-1:0] model_btn = '0;
  logic [N-1:0]  pad_w [NP];
  bit            jitter_en = 1'b0;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (valid === 1'b1) n_valid++;
  always @(posedge data_latch) n_launch++;

  // ---------------- pad models ----------------
  // Each pad loads its word on latch, presents bit 0, and moves to the next
  // bit on every rising shift clock. With jitter on, the line shows a random
  // value first and settles at a random point inside the high phase.
  int pad_idx = 0;
  always begin
    @(posedge data_latch or posedge data_pulse);
    if (data_latch === 1'b1) begin
      pad_idx = 0;
    end else begin
      if (jitter_en) begin
        data_in = NP'($urandom);
        repeat ($urandom_range(0, H - 1)) @(negedge clk);
      end
      pad_idx++;
    end
    for (int p = 0; p < NP; p++) begin
      data_in[p] = (pad_idx < N) ? pad_w[p][pad_idx] : 1'b1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] expected_word();
    logic [NW-1:0] w;
    for (int p = 0; p < NP; p++) w[p*N +: N] = ~pad_w[p];
    return w;
  endfunction

  function automatic logic [127:0] pack_obs();
    return 128'({data_latch, data_pulse, busy, valid, buttons, pressed, released});
  endfunction

  // Expected pins/report j cycles after the launch edge.
  function automatic logic [127:0] pack_exp(input int j, input logic [NW-1:0] o,
                                            input logic [NW-1:0] n);
    logic lat, pul, bsy, vld;
    logic [NW-1:0] b, pr, rl;
    lat = (j < LAT_CYC);
    pul = (j < LAT_CYC) || (j >= DONE_J) || (((j - LAT_CYC) % (2 * H)) >= H);
    bsy = (j <= DONE_J);
    vld = (j == DONE_J);
    b   = (j >= DONE_J) ? n : o;
    pr  = vld ? (n & ~o) : '0;
    rl  = vld ? (~n & o) : '0;
    return 128'({lat, pul, bsy, vld, b, pr, rl});
  endfunction

  // ---------------- driver ----------------
  // Launches (start) or waits for (auto) one poll, then checks every cycle
  // through two idle cycles after DONE. Optionally hammers start while busy
  // and drops auto_en at cycle drop_auto_j.
  task automatic poll_check(input string tag, input bit use_start, input bit spam,
                            input int drop_auto_j, output int launch_cyc);
    logic [NW-1:0] old_w, new_w;
    bit found;
    old_w = model_btn;
    new_w = expected_word();
    launch_cyc = -1;
    found = 1'b0;
    if (use_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b1;
    end else begin
      for (int w = 0; w < 1000 && !found; w++) begin
        @(negedge clk);
        found = (data_latch === 1'b1);
      end
    end
    check($sformatf("%s_launch_seen", tag), 128'(found), 128'(1));
    if (!found) return;
    launch_cyc = cyc;
    for (int j = 0; j <= DONE_J + 2; j++) begin
      check($sformatf("%s_j%0d", tag, j), pack_obs(), pack_exp(j, old_w, new_w));
      start = spam && (j <= DONE_J) && ($urandom_range(0, 2) == 0);
      if (j == drop_auto_j) auto_en = 1'b0;
      if (j < DONE_J + 2) @(negedge clk);
    end
    start = 1'b0;
    model_btn = new_w;
    exp_polls++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lc, lc_prev, c0, n0;
    for (int p = 0; p < NP; p++) pad_w[p] = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_values", pack_obs(), 128'({1'b0, 1'b1, 1'b0, 1'b0, {(3*NW){1'b0}}}));
    rst = 1'b0;
    @(negedge clk);

    // Nothing pressed, then B on pad0 plus bit 15 on pad1, repeat, release.
    poll_check("idle_word", 1'b1, 1'b0, -1, lc);
    pad_w[0] = 16'hFFFE;
    pad_w[1] = 16'h7FFF;
    poll_check("press", 1'b1, 1'b0, -1, lc);
    check("press_word", 128'(model_btn), 128'(32'h8000_0001));
    poll_check("hold", 1'b1, 1'b0, -1, lc);
    pad_w[0] = 16'hFFFF;
    pad_w[1] = 16'hFFFF;
    poll_check("release", 1'b1, 1'b0, -1, lc);

    // Random words, line jitter in the high phases, start hammered while busy.
    jitter_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
      poll_check($sformatf("rand%0d", k), 1'b1, bit'(k % 2), -1, lc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Auto polling: launches every PT cycles; drop auto_en mid third poll.
    auto_en = 1'b1;
    c0 = cyc;
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("auto1", 1'b0, 1'b0, -1, lc);
    check("auto1_time", 128'(lc - c0), 128'(PT));
    lc_prev = lc;
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("auto2", 1'b0, 1'b0, -1, lc);
    check("auto2_period", 128'(lc - lc_prev), 128'(PT));
    lc_prev = lc;
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("auto3", 1'b0, 1'b0, 50, lc);
    check("auto3_period", 128'(lc - lc_prev), 128'(PT));
    n0 = n_launch;
    repeat (2 * PT) @(negedge clk);
    check("auto_off_no_launch", 128'(n_launch - n0), 128'(0));
    check("auto_off_idle", 128'(busy), 128'(0));

    // start coincident with timer expiry: one poll, timer restarts from it.
    auto_en = 1'b1;
    c0 = cyc;
    while (cyc < c0 + PT - 1) @(negedge clk);
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("coinc", 1'b1, 1'b1, -1, lc);
    check("coinc_time", 128'(lc - c0), 128'(PT));
    lc_prev = lc;
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("coinc_next", 1'b0, 1'b1, -1, lc);
    check("coinc_next_period", 128'(lc - lc_prev), 128'(PT));
    auto_en = 1'b0;
    @(negedge clk);

    // Frame with bit 4 of pad0, then reset in the middle of bit 7 of a poll.
    pad_w[0] = 16'hFFEF;
    pad_w[1] = 16'hFFFF;
    poll_check("pre_rst", 1'b1, 1'b0, -1, lc);
    check("pre_rst_word", 128'(model_btn), 128'(32'h0000_0010));
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT_CYC + 7 * 2 * H + 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_poll", pack_obs(), 128'({1'b0, 1'b1, 1'b0, 1'b0, {(3*NW){1'b0}}}));
    @(negedge clk);
    rst = 1'b0;
    model_btn = '0;
    @(negedge clk);
    for (int p = 0; p < NP; p++) pad_w[p] = N'($urandom);
    poll_check("post_rst", 1'b1, 1'b0, -1, lc);

    check("valid_count", 128'(n_valid), 128'(exp_polls));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
